// File: rtl/mem_copy_engine.sv
// Word-granular memory copy / pattern-fill engine driving a single-port data memory.
// Copy alternates READ and WRITE per word; fill issues back-to-back WRITEs.
module mem_copy_engine #(
  parameter int unsigned LEN_W  = 7,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [31:0]       pattern_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [31:0]       mem_wd_o,
  output logic              mem_write_ena_o,
  input  logic [31:0]       mem_rd_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  count_o
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  localparam logic [ADDR_W-1:0] WordStep  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  state_e            state_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  rem_q, count_q;
  logic              fill_q;
  logic [31:0]       pat_q, buf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      pat_q   <= '0;
      buf_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            src_q   <= src_i & AlignMask;
            dst_q   <= dst_i & AlignMask;
            rem_q   <= len_i;
            count_q <= '0;
            fill_q  <= fill_i;
            pat_q   <= pattern_i;
            if (len_i == '0)  state_q <= StDone;
            else if (fill_i)  state_q <= StWrite;
            else              state_q <= StRead;
          end
        end
        StRead: begin
          buf_q   <= mem_rd_i;
          state_q <= StWrite;
        end
        StWrite: begin
          // Pointers wrap naturally at 2^ADDR_W.
          src_q   <= src_q + WordStep;
          dst_q   <= dst_q + WordStep;
          rem_q   <= rem_q - LEN_W'(1);
          count_q <= count_q + LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_q <= StDone;
          else if (fill_q)        state_q <= StWrite;
          else                    state_q <= StRead;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only, so they drop with the async reset.
  always_comb begin
    mem_a_o         = '0;
    mem_wd_o        = '0;
    mem_write_ena_o = 1'b0;
    unique case (state_q)
      StRead:  mem_a_o = src_q;
      StWrite: begin
        mem_a_o         = dst_q;
        mem_wd_o        = fill_q ? pat_q : buf_q;
        mem_write_ena_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StDone);
  assign count_o = count_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 1 KiB word memory model and write/read logs.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [31:0] src = '0, dst = '0, pattern = '0;
  logic [6:0]  len = '0;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we, busy, done;
  logic [6:0]  count;

  bit   [31:0] mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_idx = '0;
  logic [31:0] tb_wd = '0;
  logic [31:0] wr_a [64];
  logic [31:0] wr_d [64];
  logic [31:0] rd_a [64];
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.LEN_W(7), .ADDR_W(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start),
    .fill_i         (fill),
    .src_i          (src),
    .dst_i          (dst),
    .len_i          (len),
    .pattern_i      (pattern),
    .mem_a_o        (mem_a),
    .mem_wd_o       (mem_wd),
    .mem_write_ena_o(mem_we),
    .mem_rd_i       (mem_rd),
    .busy_o         (busy),
    .done_o         (done),
    .count_o        (count)
  );

  assign mem_rd = mem[mem_a[9:2]];

  // Memory and logs update mid-cycle, away from the DUT's active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_a[9:2]]  <= mem_wd;
      wr_a[wr_cnt[5:0]] <= mem_a;
      wr_d[wr_cnt[5:0]] <= mem_wd;
      wr_cnt <= wr_cnt + 1;
    end else if (tb_we) begin
      mem[tb_idx] <= tb_wd;
    end
    if (busy && !mem_we && !done) begin
      rd_a[rd_cnt[5:0]] <= mem_a;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    tb_idx = idx;
    tb_wd  = data;
    tb_we  = 1'b1;
    @(negedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Launch a transfer; lat counts edges from the accept edge (=1) to done visible.
  task automatic go(input logic f, input logic [31:0] s, input logic [31:0] d,
                    input logic [6:0] l, input logic [31:0] p, output int lat);
    fill = f; src = s; dst = d; len = l; pattern = p;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  int lat, wb, rb, ndone;

  initial begin
    // Reset values
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_a, 32'd0);
    chk("rst_wd", mem_wd, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) poke(8'(i), 32'(i + 1));
    poke(8'd4, 32'h11); poke(8'd5, 32'h12); poke(8'd6, 32'h13); poke(8'd7, 32'h14);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Copy 4 words 0x00 -> 0x40
    wb = wr_cnt;
    go(1'b0, 32'h0, 32'h40, 7'd4, 32'h0, lat);
    chk("copy_latency", 32'(lat), 32'd9);
    chk("copy_count", 32'(count), 32'd4);
    chk("copy_nwrites", 32'(wr_cnt - wb), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("copy_mem%0d", i), mem[16 + i], 32'(i + 1));
    @(posedge clk);
    #1;
    chk("copy_done_pulse", 32'(done), 32'd0);
    chk("copy_idle", 32'(busy), 32'd0);

    // Fill 3 words at 0x80
    wb = wr_cnt;
    go(1'b1, 32'h0, 32'h80, 7'd3, 32'hDEADBEEF, lat);
    chk("fill_latency", 32'(lat), 32'd4);
    chk("fill_nwrites", 32'(wr_cnt - wb), 32'd3);
    chk("fill_a0", wr_a[wb[5:0]], 32'h80);
    chk("fill_a1", wr_a[6'(wb + 1)], 32'h84);
    chk("fill_a2", wr_a[6'(wb + 2)], 32'h88);
    chk("fill_d2", wr_d[6'(wb + 2)], 32'hDEADBEEF);
    chk("fill_count", 32'(count), 32'd3);

    // Zero length
    @(posedge clk);
    #1 wb = wr_cnt;
    go(1'b0, 32'h0, 32'h40, 7'd0, 32'h0, lat);
    chk("zero_latency", 32'(lat), 32'd1);
    chk("zero_nwrites", 32'(wr_cnt - wb), 32'd0);
    chk("zero_count", 32'(count), 32'd0);

    // New start pulsed while busy must be ignored
    @(posedge clk);
    #1 wb = wr_cnt;
    fill = 1'b0; src = 32'h0; dst = 32'h100; len = 7'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    @(posedge clk);
    #1 lat++;
    fill = 1'b1; src = 32'h200; dst = 32'h300; len = 7'd5; pattern = 32'h5A5A5A5A; start = 1'b1;
    @(posedge clk);
    #1 lat++;
    start = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("busy_latency", 32'(lat), 32'd5);
    chk("busy_count", 32'(count), 32'd2);
    chk("busy_a1", wr_a[6'(wb + 1)], 32'h104);
    chk("busy_d1", wr_d[6'(wb + 1)], 32'd2);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    chk("busy_no_2nd_done", 32'(ndone), 32'd0);
    chk("busy_nwrites", 32'(wr_cnt - wb), 32'd2);

    // Misaligned, overlapping copy
    poke(8'd0, 32'hAAAA0001);
    poke(8'd1, 32'hBBBB0002);
    @(posedge clk);
    #1 wb = wr_cnt;
    rb = rd_cnt;
    go(1'b0, 32'h3, 32'h6, 7'd2, 32'h0, lat);
    chk("ovl_latency", 32'(lat), 32'd5);
    chk("ovl_rd0", rd_a[rb[5:0]], 32'h0);
    chk("ovl_rd1", rd_a[6'(rb + 1)], 32'h4);
    chk("ovl_wa0", wr_a[wb[5:0]], 32'h4);
    chk("ovl_wd0", wr_d[wb[5:0]], 32'hAAAA0001);
    chk("ovl_wa1", wr_a[6'(wb + 1)], 32'h8);
    chk("ovl_wd1", wr_d[6'(wb + 1)], 32'hAAAA0001);

    // Reset during 2nd WRITE of a 4-word copy
    @(posedge clk);
    #1 wb = wr_cnt;
    fill = 1'b0; src = 32'h10; dst = 32'h200; len = 7'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmid_in_write2", mem_a, 32'h204);
    @(negedge clk);
    #1 rst_ni = 1'b0;
    #1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_we", 32'(mem_we), 32'd0);
    chk("rmid_addr", mem_a, 32'd0);
    chk("rmid_wd", mem_wd, 32'd0);
    chk("rmid_count", 32'(count), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    fill = 1'b1; dst = 32'h300; len = 7'd1; pattern = 32'hCAFE0001; start = 1'b1;
    @(negedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("rmid_accept_we", 32'(mem_we), 32'd1);
    chk("rmid_accept_addr", mem_a, 32'h300);
    @(posedge clk);
    #1;
    chk("rmid_new_done", 32'(done), 32'd1);
    chk("rmid_nwrites", 32'(wr_cnt - wb), 32'd3);
    chk("rmid_mem2", mem[130], 32'd0);
    chk("rmid_mem3", mem[131], 32'd0);
    chk("rmid_mem1", mem[129], 32'h12);

    // Address wrap at the top of the space
    poke(8'd255, 32'h55);
    poke(8'd0, 32'h66);
    poke(8'd1, 32'h77);
    @(posedge clk);
    #1 wb = wr_cnt;
    go(1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 7'd3, 32'h0, lat);
    chk("wrap_latency", 32'(lat), 32'd7);
    chk("wrap_wa1", wr_a[6'(wb + 1)], 32'hFFFF_FFFC);
    chk("wrap_wd1", wr_d[6'(wb + 1)], 32'h66);
    chk("wrap_wa2", wr_a[6'(wb + 2)], 32'h0);
    chk("wrap_wd2", wr_d[6'(wb + 2)], 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter LEN_W, default 7, meaning the width of the word-count field (maximum 64 words).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port start_i, input, 1, request to begin a transfer; sampled only in IDLE.
REQ-006 The block SHALL have port fill_i, input, 1, transfer mode: 0 = copy, 1 = fill with pattern.
REQ-007 The block SHALL have port src_i, input, ADDR_W, source byte address (copy mode).
REQ-008 The block SHALL have port dst_i, input, ADDR_W, destination byte address.
REQ-009 The block SHALL have port len_i, input, LEN_W, number of 32-bit words to move.
REQ-010 The block SHALL have port pattern_i, input, 32, fill word (fill mode).
REQ-011 The block SHALL have port mem_a_o, output, ADDR_W, byte address to data memory.
REQ-012 The block SHALL have port mem_wd_o, output, 32, write data to data memory.
REQ-013 The block SHALL have port mem_write_ena_o, output, 1, memory write enable.
REQ-014 The block SHALL have port mem_rd_i, input, 32, combinational read data from memory for mem_a_o.
REQ-015 The block SHALL have port busy_o, output, 1, high when state is not IDLE.
REQ-016 The block SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-017 The block SHALL have port count_o, output, LEN_W, words written in the current/last transfer.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-019 In IDLE with start_i=1, the block SHALL latch src_i, dst_i, len_i, fill_i, pattern_i, clear count_o, and go to DONE if len_i=0, else WRITE if fill_i=1, else READ.
REQ-020 Latched addresses SHALL have bits [1:0] forced to 00; mem_a_o[1:0] SHALL always be 00.
REQ-021 In READ: mem_a_o = source pointer, mem_write_ena_o=0; at the edge, mem_rd_i SHALL be captured into the data buffer; next state WRITE.
REQ-022 In WRITE: mem_a_o = destination pointer, mem_wd_o = buffer (copy) or latched pattern (fill), mem_write_ena_o=1.
REQ-023 Leaving WRITE, pointers SHALL advance by 4 modulo 2^ADDR_W, remaining count SHALL decrement, count_o SHALL increment.
REQ-024 From WRITE: if remaining was 1 go to DONE; else READ (copy) or WRITE (fill).
REQ-025 In DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-026 mem_write_ena_o SHALL be 1 only in WRITE; mem_a_o and mem_wd_o SHALL be 0 in IDLE and DONE.
REQ-027 Latency after accept edge: copy 2N+1 cycles to done_o, fill N+1 cycles, len=0 one cycle.
REQ-028 start_i and all inputs except mem_rd_i SHALL be ignored while busy_o=1.
REQ-029 Overlapping regions SHALL use strict ascending word-by-word order (each read precedes the write of that word).
REQ-030 Address wrap past 0xFFFF_FFFC SHALL continue at 0x0000_0000 without error.

Reset
REQ-031 rst_ni=0 SHALL immediately force IDLE, busy_o=0, done_o=0, mem_write_ena_o=0, mem_a_o=0, mem_wd_o=0, count_o=0, buffer and pointers 0, including mid-transfer (no further writes after deassertion).
REQ-032 After rst_ni rises, the block SHALL accept start_i on the first rising edge.

Verification
REQ-033 Copy: mem[0x00..0x0C]=1,2,3,4; start src=0x00 dst=0x40 len=4 -> mem[0x40..0x4C]=1,2,3,4, done_o at cycle 9 after accept, count_o=4.
REQ-034 Fill: dst=0x80 len=3 pattern=0xDEADBEEF -> three consecutive WRITE cycles at 0x80,0x84,0x88, done_o at cycle 4.
REQ-035 Zero length: len=0 -> no mem_write_ena_o, done_o one cycle after accept, count_o=0.
REQ-036 Misaligned/overlap: src=0x03 dst=0x06 len=2 with mem[0]=A,mem[1]=B -> reads 0x00, writes 0x04 (A), reads 0x04 (A), writes 0x08 (A).
REQ-037 Reset mid-copy: assert rst_ni=0 during the 2nd WRITE of len=4 -> outputs zero asynchronously, only words 0-1 written, new start accepted immediately after release.
REQ-038 Busy ignore: pulse start_i with new args during busy -> original transfer unchanged, no second done_o.
